pulse_period_meter: RTL and testbench

- Receive-side counterpart to the pulse generator: consumes a pulse train and measures the clock-tick interval between successive rising edges.
- Reports each measured period with a one-cycle valid strobe and flags loss of pulses (timeout).
- Used to check generator outputs in hardware and to measure externally supplied tick or heartbeat signals.

---
 rtl/pulse_period_meter.sv | 127 ++++++++++++
 tb/tb_pulse_period_meter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures the clk-tick interval between successive rising edges of in, with a
// one-cycle valid strobe per period and a timeout flag. Optional: PULSE_METER_SYNC_EN.
module pulse_period_meter #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_TIMEOUT = 2'd2
  } state_e;

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_MAX = '1;

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;
  logic         in_q;
  logic         in_s;
  logic         rise;

`ifdef PULSE_METER_SYNC_EN
  // Synchronizer resets high so a line already high at reset release is no edge.
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], in};
    end
  end

  always_comb in_s = sync_q[1];
`else
  always_comb in_s = in;
`endif

  always_comb rise = in_s & ~in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      in_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      in_q      <= in_s;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (rise) state_d = S_MEASURE;
        S_MEASURE: if (!rise && cnt_q == CNT_MAX) state_d = S_TIMEOUT;
        S_TIMEOUT: if (rise) state_d = S_MEASURE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // A rise coinciding with saturation is reported as a valid maximum period.
  always_comb begin
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!ena) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = rise ? CNT_ONE : '0;
        end
        S_MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_TIMEOUT: begin
          if (rise) begin
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
          end
        end
        default: begin
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      endcase
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: N=16 and N=8 instances share one
// pulse stream; a table of pulse segments plus hand-written corner sequences.
module tb_pulse_period_meter;

`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        pin;
  logic [15:0] period16;
  logic        valid16;
  logic        timeout16;
  logic [7:0]  period8;
  logic        valid8;
  logic        timeout8;

  always #5 clk = ~clk;

  pulse_period_meter #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .ena(ena), .in(pin),
    .period(period16), .valid(valid16), .timeout(timeout16)
  );

  pulse_period_meter #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .in(pin),
    .period(period8), .valid(valid8), .timeout(timeout8)
  );

  typedef struct {
    int          hi;
    int          lo;
    int          s16;
    int          s8;
    logic [15:0] p16;
    logic [7:0]  p8;
    int          to8_idx;
    bit          t8_end;
  } vec_t;

  vec_t vecs[20];

  int nvec = 0;
  int nerr = 0;

  int          j;
  int          s16, s8, idx16, idx8, to8_idx;
  bit          prev_t8, t16_any;
  logic [15:0] per16;
  logic [7:0]  per8;

  function automatic vec_t mk(input int hi, input int lo, input int s16_e,
                              input int s8_e, input int p16_e, input int p8_e,
                              input int to8_e, input bit t8_e);
    vec_t v;
    v.hi      = hi;
    v.lo      = lo;
    v.s16     = s16_e;
    v.s8      = s8_e;
    v.p16     = p16_e[15:0];
    v.p8      = p8_e[7:0];
    v.to8_idx = to8_e;
    v.t8_end  = t8_e;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_obs();
    j       = 0;
    s16     = 0;
    s8      = 0;
    idx16   = -1;
    idx8    = -1;
    to8_idx = -1;
    t16_any = 1'b0;
  endtask

  // Observe what the last posedge produced, then drive the next cycle's inputs.
  task automatic cyc(input bit i, input bit e);
    @(negedge clk);
    if (valid16 === 1'b1) begin
      if (s16 == 0) idx16 = j;
      s16++;
      per16 = period16;
    end
    if (valid8 === 1'b1) begin
      if (s8 == 0) idx8 = j;
      s8++;
      per8 = period8;
    end
    if (timeout8 === 1'b1 && !prev_t8 && to8_idx < 0) to8_idx = j;
    prev_t8 = (timeout8 === 1'b1);
    if (timeout16 !== 1'b0) t16_any = 1'b1;
    j++;
    pin = i;
    ena = e;
  endtask

  task automatic seg(input int hi, input int lo, input bit e);
    for (int k = 0; k < hi; k++) cyc(1'b1, e);
    for (int k = 0; k < lo; k++) cyc(1'b0, e);
  endtask

  initial begin
    vecs[0] = mk(1, 119, 0, 0, 0, 0, -1, 1'b0);
    for (int i = 1; i <= 9; i++) vecs[i] = mk(1, 119, 1, 1, 120, 120, -1, 1'b0);
    for (int i = 10; i <= 13; i++) vecs[i] = mk(50, 70, 1, 1, 120, 120, -1, 1'b0);
    vecs[14] = mk(1, 299, 1, 1, 120, 120, 256 + LAT, 1'b1);
    vecs[15] = mk(1, 99, 1, 0, 300, 120, -1, 1'b0);
    vecs[16] = mk(1, 254, 1, 1, 100, 100, -1, 1'b0);
    vecs[17] = mk(1, 255, 1, 1, 255, 255, -1, 1'b0);
    vecs[18] = mk(1, 99, 1, 0, 256, 255, LAT, 1'b0);
    vecs[19] = mk(1, 119, 1, 1, 100, 100, -1, 1'b0);

    prev_t8 = 1'b0;
    per16   = '0;
    per8    = '0;
    rst     = 1'b1;
    ena     = 1'b1;
    pin     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst period16", int'(period16), 0);
    chk("rst valid16", int'(valid16), 0);
    chk("rst timeout16", int'(timeout16), 0);
    chk("rst period8", int'(period8), 0);
    chk("rst valid8", int'(valid8), 0);
    chk("rst timeout8", int'(timeout8), 0);
    rst = 1'b0;

    // Table: each segment drives hi cycles high then lo low; rise at its first cycle.
    for (int i = 0; i < 20; i++) begin
      clear_obs();
      seg(vecs[i].hi, vecs[i].lo, 1'b1);
      chk($sformatf("v%0d strobes16", i), s16, vecs[i].s16);
      chk($sformatf("v%0d strobe_at16", i), idx16, (vecs[i].s16 > 0) ? 1 + LAT : -1);
      chk($sformatf("v%0d period16", i), int'(period16), int'(vecs[i].p16));
      chk($sformatf("v%0d strobes8", i), s8, vecs[i].s8);
      chk($sformatf("v%0d strobe_at8", i), idx8, (vecs[i].s8 > 0) ? 1 + LAT : -1);
      chk($sformatf("v%0d period8", i), int'(period8), int'(vecs[i].p8));
      chk($sformatf("v%0d timeout8_rise_at", i), to8_idx, vecs[i].to8_idx);
      chk($sformatf("v%0d timeout8_end", i), int'(timeout8), int'(vecs[i].t8_end));
      chk($sformatf("v%0d timeout16_seen", i), int'(t16_any), 0);
    end

    // Enable dropped 60 ticks into an interval.
    clear_obs();
    seg(1, 59, 1'b1);
    chk("ena pre strobes16", s16, 1);
    chk("ena pre period16", int'(per16), 120);
    clear_obs();
    seg(0, 5, 1'b0);
    chk("ena off strobes16", s16, 0);
    chk("ena off strobes8", s8, 0);
    chk("ena off period16", int'(period16), 120);
    chk("ena off period8", int'(period8), 120);
    clear_obs();
    seg(1, 119, 1'b1);
    chk("ena first rise strobes16", s16, 0);
    chk("ena first rise strobes8", s8, 0);
    clear_obs();
    seg(1, 119, 1'b1);
    chk("ena second rise strobes16", s16, 1);
    chk("ena second rise period16", int'(per16), 120);
    chk("ena second rise period8", int'(per8), 120);

    // Minimum-period train: 1 high, 1 low.
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b1);
    end
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1);
    chk("minper strobes16", s16, 4);
    chk("minper strobes8", s8, 4);
    chk("minper period16", int'(period16), 2);
    chk("minper period8", int'(period8), 2);

    // Reset while timed out, with the input held high through release.
    clear_obs();
    seg(1, 299, 1'b1);
    chk("pre-rst timeout8", int'(timeout8), 1);
    chk("pre-rst period16", int'(period16), 12);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    clear_obs();
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1);
    chk("rst mid period16", int'(period16), 0);
    chk("rst mid period8", int'(period8), 0);
    chk("rst mid timeout8", int'(timeout8), 0);
    chk("rst held-high strobes16", s16, 0);
    chk("rst held-high strobes8", s8, 0);
    seg(0, 10, 1'b1);
    clear_obs();
    seg(1, 119, 1'b1);
    chk("post-rst first rise strobes16", s16, 0);
    chk("post-rst first rise strobes8", s8, 0);
    clear_obs();
    seg(1, 9, 1'b1);
    chk("post-rst second rise strobes16", s16, 1);
    chk("post-rst second rise period16", int'(per16), 120);
    chk("post-rst second rise period8", int'(per8), 120);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
